// File: rtl/adc_apb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_apb_sequencer
// Brief    : APB initiator that scans ADC channels from a mask: select AMUX,
//            trigger, poll status, read measurement, present one result.
//            Optional status-poll timeout enabled by macro ADC_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module adc_apb_sequencer #(
    parameter int ADDR_WIDTH      = 12,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_CH          = 8,
    parameter int STATUS_DONE_BIT = 0,
    parameter int POLL_LIMIT      = 255,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  start,
    input  logic [NUM_CH-1:0]     chan_mask,
    output logic                  busy,
    output logic                  done,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CH_W-1:0]       res_chan,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_err
);

    localparam logic [ADDR_WIDTH-1:0] c_addr_status = ADDR_WIDTH'(12'h001);
    localparam logic [ADDR_WIDTH-1:0] c_addr_meas   = ADDR_WIDTH'(12'h003);
    localparam logic [ADDR_WIDTH-1:0] c_addr_amux   = ADDR_WIDTH'(12'h101);
    localparam logic [ADDR_WIDTH-1:0] c_addr_trig   = ADDR_WIDTH'(12'h102);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL_CH, S_WR_AMUX, S_WR_TRIG, S_RD_STAT, S_RD_MEAS, S_PUSH, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_CH-1:0]       mask_q, mask_d;
    logic [CH_W:0]           ptr_q, ptr_d;
    logic [CH_W-1:0]         res_chan_q, res_chan_d;
    logic [DATA_WIDTH-1:0]   res_data_q, res_data_d;
    logic                    res_err_q, res_err_d;
    logic                    res_valid_q, res_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                    xfer_done;
    logic                    found;
    logic [CH_W-1:0]         sel;

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int POLL_W = ($clog2(POLL_LIMIT + 1) > 8) ? $clog2(POLL_LIMIT + 1) : 8;
    localparam logic [POLL_W-1:0] c_poll_last = POLL_W'(POLL_LIMIT - 1);
    logic [POLL_W-1:0] poll_q, poll_d;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) poll_q <= '0;
        else        poll_q <= poll_d;
    end
`endif

    assign xfer_done = psel_q && penable_q && PREADY;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        ptr_d      = ptr_q;
        res_chan_d = res_chan_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
`ifdef ADC_SEQ_TIMEOUT_EN
        poll_d     = poll_q;
`endif
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && mask_q[i] && ((CH_W+1)'(i) >= ptr_q)) begin
                found = 1'b1;
                sel   = CH_W'(i);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d  = chan_mask;
                    ptr_d   = '0;
                    state_d = S_SEL_CH;
                end
            end
            S_SEL_CH: begin
                if (found) begin
                    res_chan_d = sel;
                    res_data_d = '0;
                    res_err_d  = 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
                    poll_d     = '0;
`endif
                    state_d    = S_WR_AMUX;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WR_AMUX: if (xfer_done) state_d = S_WR_TRIG;
            S_WR_TRIG: if (xfer_done) state_d = S_RD_STAT;
            S_RD_STAT: begin
                if (xfer_done) begin
                    if (PRDATA[STATUS_DONE_BIT]) begin
                        state_d = S_RD_MEAS;
                    end
`ifdef ADC_SEQ_TIMEOUT_EN
                    else if (poll_q == c_poll_last) begin
                        state_d    = S_PUSH;
                        res_err_d  = 1'b1;
                        res_data_d = '0;
                    end else begin
                        poll_d = poll_q + POLL_W'(1);
                    end
`endif
                end
            end
            S_RD_MEAS: begin
                if (xfer_done) begin
                    res_data_d = PRDATA;
                    state_d    = S_PUSH;
                end
            end
            S_PUSH: begin
                if (res_ready) begin
                    ptr_d   = {1'b0, res_chan_q} + (CH_W+1)'(1);
                    state_d = S_SEL_CH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A slave error on any transfer abandons the channel.
        if (xfer_done && PSLVERR) begin
            state_d    = S_PUSH;
            res_err_d  = 1'b1;
            res_data_d = '0;
        end

        // Outputs are registered copies derived from the next state.
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        res_valid_d = (state_d == S_PUSH);
        psel_d      = (state_d == S_WR_AMUX) || (state_d == S_WR_TRIG) ||
                      (state_d == S_RD_STAT) || (state_d == S_RD_MEAS);
        penable_d   = psel_q && (!penable_q || !PREADY);
        pwrite_d    = (state_d == S_WR_AMUX) || (state_d == S_WR_TRIG);
        paddr_d     = '0;
        pwdata_d    = '0;
        case (state_d)
            S_WR_AMUX: begin paddr_d = c_addr_amux;   pwdata_d = DATA_WIDTH'(res_chan_d); end
            S_WR_TRIG: begin paddr_d = c_addr_trig;   pwdata_d = DATA_WIDTH'(1);          end
            S_RD_STAT: paddr_d = c_addr_status;
            S_RD_MEAS: paddr_d = c_addr_meas;
            default:   paddr_d = '0;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            ptr_q       <= '0;
            res_chan_q  <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ptr_q       <= ptr_d;
            res_chan_q  <= res_chan_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign res_valid = res_valid_q;
    assign res_chan  = res_chan_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_apb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_apb_sequencer
// Brief    : Self-checking bench for adc_apb_sequencer with an APB slave model
//            and scoreboards for APB writes and results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_apb_sequencer;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        start;
    logic [7:0]  chan_mask;
    logic        busy, done;
    logic        PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic        res_valid, res_ready, res_err;
    logic [2:0]  res_chan;
    logic [31:0] res_data;

    int vectors = 0;
    int miscompares = 0;

    // Slave model knobs
    int          trig_wait = 0;
    logic        err_amux  = 1'b0;
    logic        stat_done = 1'b1;
    logic        sink_ready = 1'b1;
    logic [31:0] meas [8];
    logic [2:0]  cur_ch = 3'd0;
    int          acc_cnt;
    int          stat_reads = 0;
    int          psel_cycles = 0;
    int          last_trig_len = 0;
    int          acc_len = 0;
    logic [11:0] setup_addr;
    logic        setup_wr;
    logic [31:0] setup_wd;

    typedef struct packed { logic [11:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [2:0] ch; logic [31:0] data; logic err; } res_t;
    wr_t  exp_wr  [$];
    res_t exp_res [$];

    adc_apb_sequencer #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_CH(8), .STATUS_DONE_BIT(0), .POLL_LIMIT(4)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .start(start), .chan_mask(chan_mask),
        .busy(busy), .done(done), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .res_valid(res_valid), .res_ready(res_ready),
        .res_chan(res_chan), .res_data(res_data), .res_err(res_err)
    );

    always #5 PCLK = ~PCLK;

    assign res_ready = sink_ready;
    assign PREADY  = !(PSEL && PENABLE && (PADDR == 12'h102) && (acc_cnt < trig_wait));
    assign PSLVERR = PSEL && PENABLE && PWRITE && (PADDR == 12'h101) && err_amux;
    assign PRDATA  = (PADDR == 12'h001) ? {31'b0, stat_done} :
                     (PADDR == 12'h003) ? meas[cur_ch] : 32'h0;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET)                          acc_cnt <= 0;
        else if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                                 acc_cnt <= 0;
    end

    // Bus and result monitor: protocol stability plus both scoreboards.
    always @(negedge PCLK) begin
        wr_t  w;
        res_t r;
        if (!PRESET) begin
            if (PSEL) psel_cycles++;
            if (PSEL && !PENABLE) begin
                setup_addr = PADDR; setup_wr = PWRITE; setup_wd = PWDATA; acc_len = 0;
            end
            if (PSEL && PENABLE) begin
                acc_len++;
                vectors++;
                if ({PADDR, PWRITE, PWDATA} !== {setup_addr, setup_wr, setup_wd}) begin
                    miscompares++;
                    $display("FAIL apb_stable: got addr %h wr %b data %h, setup had addr %h wr %b data %h",
                             PADDR, PWRITE, PWDATA, setup_addr, setup_wr, setup_wd);
                end
                if (PREADY) begin
                    if (PADDR == 12'h102) last_trig_len = acc_len;
                    if (PADDR == 12'h001 && !PWRITE) stat_reads++;
                    if (PADDR == 12'h101 && PWRITE) cur_ch = PWDATA[2:0];
                    if (PWRITE) begin
                        vectors++;
                        if (exp_wr.size() == 0) begin
                            miscompares++;
                            $display("FAIL apb_write: unexpected write addr %h data %h", PADDR, PWDATA);
                        end else begin
                            w = exp_wr.pop_front();
                            if ({PADDR, PWDATA} !== {w.addr, w.data}) begin
                                miscompares++;
                                $display("FAIL apb_write: got addr %h data %h expected addr %h data %h",
                                         PADDR, PWDATA, w.addr, w.data);
                            end
                        end
                    end
                end
            end
            if (res_valid && res_ready) begin
                vectors++;
                if (exp_res.size() == 0) begin
                    miscompares++;
                    $display("FAIL result: unexpected result chan %0d data %h err %b", res_chan, res_data, res_err);
                end else begin
                    r = exp_res.pop_front();
                    if ({res_chan, res_data, res_err} !== {r.ch, r.data, r.err}) begin
                        miscompares++;
                        $display("FAIL result: got chan %0d data %h err %b expected chan %0d data %h err %b",
                                 res_chan, res_data, res_err, r.ch, r.data, r.err);
                    end
                end
            end
        end
    end

    task automatic push_chan(input logic [2:0] ch, input logic with_trig);
        exp_wr.push_back({12'h101, {29'b0, ch}});
        if (with_trig) exp_wr.push_back({12'h102, 32'h1});
    endtask

    task automatic start_scan(input logic [7:0] mask);
        @(negedge PCLK);
        start = 1'b1; chan_mask = mask;
        @(negedge PCLK);
        start = 1'b0; chan_mask = 8'hFF;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        bit seen;
        seen = 0;
        cyc = 1;
        while (!seen && cyc < budget) begin
            @(negedge PCLK);
            cyc++;
            if (done) seen = 1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL done_seen: no done pulse within %0d cycles", budget);
        end else begin
            @(negedge PCLK);
            vectors++;
            if ({done, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL done_pulse: got done %b busy %b expected 0 0", done, busy);
            end
        end
    endtask

    task automatic check_queues_empty(input string name);
        vectors++;
        if (exp_wr.size() != 0 || exp_res.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d writes %0d results left, expected 0 0",
                     name, exp_wr.size(), exp_res.size());
        end
    endtask

    task automatic test_reset;
        @(negedge PCLK);
        vectors++;
        if ({PSEL, PENABLE, PWRITE, busy, done, res_valid, res_err} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {PSEL, PENABLE, PWRITE, busy, done, res_valid, res_err});
        end
        vectors++;
        if ({PADDR, PWDATA, res_data, res_chan} !== 79'b0) begin
            miscompares++;
            $display("FAIL reset_data: got paddr %h pwdata %h res_data %h res_chan %0d expected 0",
                     PADDR, PWDATA, res_data, res_chan);
        end
        PRESET = 1'b0;
    endtask

    task automatic test_empty_mask;
        int cyc, p0;
        p0 = psel_cycles;
        start_scan(8'h00);
        wait_done(20, cyc);
        vectors++;
        if (cyc !== 2) begin
            miscompares++;
            $display("FAIL empty_latency: got done at cycle %0d expected 2", cyc);
        end
        vectors++;
        if (psel_cycles !== p0) begin
            miscompares++;
            $display("FAIL empty_apb: got %0d PSEL cycles expected 0", psel_cycles - p0);
        end
    endtask

    task automatic test_basic;
        int cyc;
        stat_reads = 0;
        push_chan(3'd0, 1'b1); push_chan(3'd2, 1'b1);
        exp_res.push_back({3'd0, 32'hABC, 1'b0});
        exp_res.push_back({3'd2, 32'h123, 1'b0});
        start_scan(8'b0000_0101);
        wait_done(200, cyc);
        vectors++;
        if (cyc !== 22) begin
            miscompares++;
            $display("FAIL basic_latency: got done at cycle %0d expected 22", cyc);
        end
        vectors++;
        if (stat_reads !== 2) begin
            miscompares++;
            $display("FAIL basic_stat_reads: got %0d expected 2", stat_reads);
        end
        check_queues_empty("basic");
    endtask

    task automatic test_wait_trig;
        int cyc;
        trig_wait = 3; last_trig_len = 0;
        push_chan(3'd1, 1'b1);
        exp_res.push_back({3'd1, 32'h555, 1'b0});
        start_scan(8'h02);
        wait_done(200, cyc);
        vectors++;
        if (last_trig_len !== 4) begin
            miscompares++;
            $display("FAIL trig_wait_len: got %0d access cycles expected 4", last_trig_len);
        end
        trig_wait = 0;
        check_queues_empty("trig_wait");
    endtask

    task automatic test_slverr;
        int cyc;
        err_amux = 1'b1;
        push_chan(3'd1, 1'b0);
        exp_res.push_back({3'd1, 32'h0, 1'b1});
        start_scan(8'h02);
        wait_done(200, cyc);
        err_amux = 1'b0;
        check_queues_empty("slverr");
    endtask

    task automatic test_backpressure;
        int cyc, p0;
        bit hit;
        sink_ready = 1'b0;
        push_chan(3'd0, 1'b1);
        exp_res.push_back({3'd0, 32'hABC, 1'b0});
        start_scan(8'h01);
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge PCLK);
            if (res_valid) hit = 1;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL bp_valid: got no res_valid within 50 cycles expected valid");
        end
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            @(negedge PCLK);
            vectors++;
            if ({res_valid, res_chan, res_data, res_err, PSEL} !== {1'b1, 3'd0, 32'hABC, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL bp_hold: got valid %b chan %0d data %h err %b psel %b expected 1 0 abc 0 0",
                         res_valid, res_chan, res_data, res_err, PSEL);
            end
        end
        start = 1'b0;
        sink_ready = 1'b1;
        wait_done(50, cyc);
        p0 = psel_cycles;
        repeat (5) @(negedge PCLK);
        vectors++;
        if (busy !== 1'b0 || psel_cycles !== p0) begin
            miscompares++;
            $display("FAIL bp_start_ignored: got busy %b psel cycles %0d expected 0 0", busy, psel_cycles - p0);
        end
        check_queues_empty("bp");
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit hit;
        stat_done = 1'b0; stat_reads = 0;
        push_chan(3'd0, 1'b1);
        start_scan(8'h01);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge PCLK);
            if (stat_reads >= 2 && PSEL && PENABLE && PADDR == 12'h001) hit = 1;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL rst_mid_reach: got no status access within 100 cycles expected one");
        end
        #2 PRESET = 1'b1;
        #1;
        vectors++;
        if ({PSEL, PENABLE, busy, res_valid} !== 4'b0) begin
            miscompares++;
            $display("FAIL rst_mid_drop: got psel %b penable %b busy %b valid %b expected 0",
                     PSEL, PENABLE, busy, res_valid);
        end
        @(negedge PCLK);
        PRESET = 1'b0;
        check_queues_empty("rst_mid");
        stat_done = 1'b1;
        push_chan(3'd0, 1'b1);
        exp_res.push_back({3'd0, 32'hABC, 1'b0});
        start_scan(8'h01);
        wait_done(100, cyc);
        vectors++;
        if (cyc !== 12) begin
            miscompares++;
            $display("FAIL rst_mid_rerun: got done at cycle %0d expected 12", cyc);
        end
        check_queues_empty("rst_rerun");
    endtask

    task automatic test_poll_timeout;
        stat_done = 1'b0; stat_reads = 0;
        push_chan(3'd0, 1'b1);
`ifdef ADC_SEQ_TIMEOUT_EN
        begin
            int cyc;
            exp_res.push_back({3'd0, 32'h0, 1'b1});
            start_scan(8'h01);
            wait_done(200, cyc);
            vectors++;
            if (stat_reads !== 4) begin
                miscompares++;
                $display("FAIL timeout_reads: got %0d expected 4", stat_reads);
            end
        end
`else
        start_scan(8'h01);
        for (int i = 0; i < 400 && stat_reads <= 100; i++) @(negedge PCLK);
        vectors++;
        if (stat_reads <= 100 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL poll_forever: got %0d reads valid %b expected >100 reads valid 0",
                     stat_reads, res_valid);
        end
        #2 PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
`endif
        stat_done = 1'b1;
        check_queues_empty("poll");
    endtask

    initial begin
        PRESET = 1'b1; start = 1'b0; chan_mask = 8'h00;
        for (int i = 0; i < 8; i++) meas[i] = 32'h0;
        meas[0] = 32'hABC; meas[1] = 32'h555; meas[2] = 32'h123;
        repeat (2) @(negedge PCLK);
        test_reset;
        test_empty_mask;
        test_basic;
        test_wait_trig;
        test_slverr;
        test_backpressure;
        test_reset_mid;
        test_poll_timeout;
        repeat (3) @(negedge PCLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_apb_sequencer.md
# adc_apb_sequencer

APB initiator that autonomously scans the ADC peripheral across a channel mask. For each enabled channel it issues APB writes to select the AMUX input and fire the trigger, polls the status register until conversion completes, reads the measurement, and presents it on a one-entry result port. It sits between the PCLK-domain control logic and the ADC APB slave, driving the other end of that slave's APB interface.

## Interface

- ADDR_WIDTH, 12, APB address width
- DATA_WIDTH, 32, APB data width
- NUM_CH, 8, number of AMUX channels; CH_W = $clog2(NUM_CH), minimum 1
- STATUS_DONE_BIT, 0, bit of the status word that indicates conversion complete
- POLL_LIMIT, 255, maximum status reads per channel (used only with ADC_SEQ_TIMEOUT_EN)

- PCLK  in  1  clock
- PRESET  in  1  asynchronous reset, active-high
- start  in  1  scan request, sampled only in IDLE
- chan_mask  in  NUM_CH  enabled channels, latched on an accepted start
- busy  out  1  high from the cycle after start acceptance until DONE exits
- done  out  1  one-cycle pulse at scan end
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  completer ready
- PSLVERR  in  1  completer error, sampled with PREADY
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_chan  out  CH_W  channel of the result
- res_data  out  DATA_WIDTH  measurement, or 0 on error
- res_err  out  1  set on PSLVERR or poll timeout

## Operation

- Fixed register offsets: STATUS 0x001, MEASUREMENT 0x003, AMUX 0x101, TRIGGER 0x102.
- States: IDLE, SEL_CH, WR_AMUX, WR_TRIG, RD_STAT, RD_MEAS, PUSH, DONE.
- IDLE: start=1 latches chan_mask, sets channel pointer to 0, and moves to SEL_CH.
- SEL_CH: finds the lowest enabled channel ≥ pointer and goes to WR_AMUX. If no such channel exists, goes to DONE.
- WR_AMUX writes the channel index, zero-extended, to 0x101. WR_TRIG writes 0x00000001 to 0x102.
- RD_STAT reads 0x001 and repeats until PRDATA[STATUS_DONE_BIT]=1, then goes to RD_MEAS. RD_MEAS reads 0x003 and captures PRDATA into res_data.
- Every APB transfer has a setup cycle (PSEL=1, PENABLE=0) and access cycles (PENABLE=1) that are held until PREADY=1. PADDR, PWRITE and PWDATA stay stable throughout the transfer.
- Consecutive transfers run back-to-back: PSEL stays high and PENABLE drops for the next setup. PSEL=0 in SEL_CH, PUSH, DONE and IDLE.
- If PSLVERR=1 at completion of any transfer, the channel is abandoned: res_err=1, res_data=0, and the state goes to PUSH.
- PUSH: res_valid=1 holds res_chan, res_data and res_err stable until res_ready=1. Then the pointer becomes channel+1 and the state goes to SEL_CH. When the pointer reaches NUM_CH, the next SEL_CH goes to DONE.
- DONE: done=1 for one cycle, then IDLE. busy drops in the same cycle IDLE is entered.
- start while busy is ignored. chan_mask changes during a scan have no effect.
- res_valid and res_ready both high in PUSH completes the handshake at that edge.

## Timing

- Reset values: PSEL, PENABLE, PWRITE, busy, done, res_valid, res_err = 0. PADDR, PWDATA, res_data, res_chan = 0. State = IDLE.
- PRESET asserted mid-transfer drops PSEL and PENABLE immediately, with no completion. Any pending result is discarded.
- Start sampled at edge E0: SEL_CH after E0, WR_AMUX setup after E1, access after E2, complete at E3 with PREADY=1.
- Zero-wait-state channel cost is 1 (SEL_CH) + 2 + 2 + 2k (k status reads) + 2 + 1 (PUSH with res_ready=1) cycles.
- chan_mask=0: DONE after E1 and done=1 for one cycle. No APB activity.
- All outputs are registered.

## Configuration

- ADC_SEQ_TIMEOUT_EN defined: an 8+ bit poll counter is added. When the POLL_LIMIT-th status read completes without the done bit, the channel gets res_err=1, res_data=0 and goes to PUSH.
- ADC_SEQ_TIMEOUT_EN undefined: RD_STAT polls indefinitely, and POLL_LIMIT is unused.

## Test plan

- chan_mask=8'b0000_0101, zero-wait slave, status done on the 1st read, MEAS=0xABC / 0x123 → two results (chan 0, 0xABC, err 0) and (chan 2, 0x123, err 0). AMUX writes 0 and 2, two TRIG writes of 1, then done.
- PREADY held low for 3 cycles on the TRIG write → PENABLE stays high for 4 cycles with PADDR=0x102 and PWDATA=1 stable throughout.
- PSLVERR=1 on the ch1 AMUX write, mask=8'h02 → result (chan 1, data 0, err 1), no TRIG write issued, done pulse.
- Status never completes, timeout enabled, POLL_LIMIT=4 → exactly 4 status reads, then res_err=1. Without the macro, polling continues for more than 100 reads.
- res_ready held low for 10 cycles → res_valid and the result hold, with no APB activity. start=1 during the scan is ignored.
- PRESET pulsed during RD_STAT access → PSEL=0 and busy=0 immediately. A new start=1 with mask=8'h01 completes normally.
